alu_result_packer: RTL

- Downstream stage of the arithmetic unit. Captures every cycle in which the arithmetic flag is high and queues the signed result.
- Streams each result out as a byte packet, LSB first, over a valid/ready byte interface toward the UART/TX framing stage.
- Results that arrive while the queue is full are dropped and counted.

---
 rtl/alu_pack_pkg.sv | 24 ++
 rtl/alu_result_packer_fifo.sv | 63 ++++++
 rtl/alu_result_packer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pack_pkg.sv
// alu_pack_pkg: shared constants, packet-size helper and FSM encoding
// for the alu_result_packer slice.
package alu_pack_pkg;

  // Width of one packet byte on the output stream.
  localparam int BYTE_W = 8;

  // All-ones pattern used as the saturation ceiling of the drop counter.
  // Sliced down to the counter width at the point of use.
  localparam logic [31:0] DROP_SAT_ALL_ONES = '1;

  // Packer FSM encoding. CHK is only reachable when the checksum byte is enabled.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CHK  = 2'd2
  } pack_state_t;

  // Number of whole bytes needed to carry a result of result_w bits.
  function automatic int num_bytes(input int result_w);
    return (result_w + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/alu_result_packer_fifo.sv
// result_fifo: synchronous FIFO holding arithmetic results awaiting packing.
// A push while full is still accepted when a pop frees a slot on the same edge.
// DEPTH must be a power of two (2..16).
module result_fifo
  import alu_pack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             CLK_pack,
  input  logic             RST_pack,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             push_accept,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign push_accept = do_push;

  // Head of queue is visible combinationally so the packer can load it on the pop edge.
  assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

  // Storage array: written on accepted pushes, contents need no reset.
  always_ff @(posedge CLK_pack) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointer advance.
  always_ff @(posedge CLK_pack or negedge RST_pack) begin
    if (!RST_pack) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/alu_result_packer.sv
// alu_result_packer: queues signed arithmetic results and streams each one as a
// little-endian, sign-extended byte packet over a valid/ready byte interface.
// Results arriving with the queue full are dropped and counted (saturating).
// Build option: define ALU_PACK_CHECKSUM_EN to append an XOR checksum byte
// to every packet (Byte_Last then marks the checksum byte).
module alu_result_packer
  import alu_pack_pkg::*;
#(
  parameter int WIDTH_OUT_DATA = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_W     = 8
) (
  input  logic                        CLK_pack,
  input  logic                        RST_pack,
  input  logic signed [WIDTH_OUT_DATA:0] Arith_OUT_pack,
  input  logic                        Arith_Flag_pack,
  output logic [BYTE_W-1:0]           Byte_Data,
  output logic                        Byte_Valid,
  input  logic                        Byte_Ready,
  output logic                        Byte_Last,
  output logic                        Pack_Busy,
  output logic [DROP_CNT_W-1:0]       Drop_Cnt
);

  localparam int RES_W     = WIDTH_OUT_DATA + 1;
  localparam int NUM_BYTES = num_bytes(RES_W);
  localparam int PACK_W    = NUM_BYTES * BYTE_W;
  localparam int IDX_W     = $clog2(NUM_BYTES + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = DROP_SAT_ALL_ONES[DROP_CNT_W-1:0];

  pack_state_t             state_reg;
  logic [PACK_W-1:0]       shift_reg;
  logic [PACK_W-1:0]       shift_next;
  logic [PACK_W-1:0]       head_ext;
  logic [BYTE_W-1:0]       byte_data_reg;
  logic                    byte_valid_reg;
  logic                    byte_last_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [DROP_CNT_W-1:0]   drop_cnt_reg;
  logic [RES_W-1:0]        fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    fifo_push_accept;
  logic                    xfer;
`ifdef ALU_PACK_CHECKSUM_EN
  logic [BYTE_W-1:0]       chk_reg;
`endif

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .CLK_pack    (CLK_pack),
    .RST_pack    (RST_pack),
    .push        (Arith_Flag_pack),
    .push_data   (Arith_OUT_pack),
    .pop         (fifo_pop),
    .head_data   (fifo_head),
    .push_accept (fifo_push_accept),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // The packer only pops while idle; that pop frees a slot for a same-edge push.
  assign fifo_pop   = (state_reg == IDLE) && !fifo_empty;
  assign xfer       = byte_valid_reg && Byte_Ready;
  assign head_ext   = PACK_W'($signed(fifo_head));
  assign shift_next = shift_reg >> BYTE_W;

  assign Byte_Data  = byte_data_reg;
  assign Byte_Valid = byte_valid_reg;
  assign Byte_Last  = byte_last_reg;
  assign Pack_Busy  = !fifo_empty || (state_reg != IDLE);
  assign Drop_Cnt   = drop_cnt_reg;

  // Packet FSM: load a result from the queue, then shift it out one byte per transfer.
  always_ff @(posedge CLK_pack or negedge RST_pack) begin
    if (!RST_pack) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      byte_data_reg  <= '0;
      byte_valid_reg <= 1'b0;
      byte_last_reg  <= 1'b0;
      idx_reg        <= '0;
`ifdef ALU_PACK_CHECKSUM_EN
      chk_reg        <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            shift_reg      <= head_ext;
            byte_data_reg  <= head_ext[BYTE_W-1:0];
            byte_valid_reg <= 1'b1;
            idx_reg        <= '0;
            state_reg      <= SEND;
`ifdef ALU_PACK_CHECKSUM_EN
            chk_reg        <= '0;
            byte_last_reg  <= 1'b0;
`else
            byte_last_reg  <= (LAST_IDX == '0);
`endif
          end
        end
        SEND: begin
          if (xfer) begin
`ifdef ALU_PACK_CHECKSUM_EN
            chk_reg <= chk_reg ^ byte_data_reg;
`endif
            if (idx_reg == LAST_IDX) begin
`ifdef ALU_PACK_CHECKSUM_EN
              // Final data byte accepted: present the running XOR as a trailer.
              byte_data_reg <= chk_reg ^ byte_data_reg;
              byte_last_reg <= 1'b1;
              state_reg     <= CHK;
`else
              byte_data_reg  <= '0;
              byte_valid_reg <= 1'b0;
              byte_last_reg  <= 1'b0;
              state_reg      <= IDLE;
`endif
            end else begin
              idx_reg       <= idx_reg + IDX_W'(1);
              shift_reg     <= shift_next;
              byte_data_reg <= shift_next[BYTE_W-1:0];
`ifndef ALU_PACK_CHECKSUM_EN
              byte_last_reg <= ((idx_reg + IDX_W'(1)) == LAST_IDX);
`endif
            end
          end
        end
`ifdef ALU_PACK_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            byte_data_reg  <= '0;
            byte_valid_reg <= 1'b0;
            byte_last_reg  <= 1'b0;
            state_reg      <= IDLE;
          end
        end
`endif
        default: begin
          byte_valid_reg <= 1'b0;
          byte_last_reg  <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of results the queue could not accept.
  always_ff @(posedge CLK_pack or negedge RST_pack) begin
    if (!RST_pack) begin
      drop_cnt_reg <= '0;
    end else if (Arith_Flag_pack && !fifo_push_accept && (drop_cnt_reg != DROP_MAX)) begin
      drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
    end
  end

endmodule
